// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour command sequencer.
// Holds command opcodes, compass headings, response bytes, the sequencer
// state type and a small command-packing helper.
package tour_pkg;

  // Command opcodes understood by the command processor
  localparam logic [3:0] OP_MOVE     = 4'h2;
  localparam logic [3:0] OP_MOVE_FAN = 4'h3;

  // Compass headings in the command processor's heading units
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes returned to the UART wrapper
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VERT   = 3'd1,
    ST_HOLD_V = 3'd2,
    ST_HORZ   = 3'd3,
    ST_HOLD_H = 3'd4
  } tour_state_t;

  // Assemble a command word: [15:12] opcode, [11:4] heading, [3:0] squares
  function automatic logic [15:0] pack_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Combinational decoder from a one-hot knight move to two straight-line
// commands: a vertical leg (MOVE) followed by a horizontal leg (MOVE_FANFARE).
// Ports:
//   move     in  8   one-hot knight move (bit0..bit7, see table below)
//   vert_cmd out 16  vertical leg command
//   horz_cmd out 16  horizontal leg command
// A move that is not exactly one-hot decodes to a zero-length move north on
// both legs, so a corrupt solver entry never sends the robot anywhere.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic [7:0] vert_hdg_s;
  logic [3:0] vert_sq_s;
  logic [7:0] horz_hdg_s;
  logic [3:0] horz_sq_s;

  // Map each one-hot move to heading and distance of its two legs
  always_comb begin
    vert_hdg_s = HDG_N;
    vert_sq_s  = 4'd0;
    horz_hdg_s = HDG_N;
    horz_sq_s  = 4'd0;
    case (move)
      8'h01: begin vert_hdg_s = HDG_N; vert_sq_s = 4'd2; horz_hdg_s = HDG_E; horz_sq_s = 4'd1; end // (+1,+2)
      8'h02: begin vert_hdg_s = HDG_N; vert_sq_s = 4'd2; horz_hdg_s = HDG_W; horz_sq_s = 4'd1; end // (-1,+2)
      8'h04: begin vert_hdg_s = HDG_N; vert_sq_s = 4'd1; horz_hdg_s = HDG_W; horz_sq_s = 4'd2; end // (-2,+1)
      8'h08: begin vert_hdg_s = HDG_S; vert_sq_s = 4'd1; horz_hdg_s = HDG_W; horz_sq_s = 4'd2; end // (-2,-1)
      8'h10: begin vert_hdg_s = HDG_S; vert_sq_s = 4'd2; horz_hdg_s = HDG_W; horz_sq_s = 4'd1; end // (-1,-2)
      8'h20: begin vert_hdg_s = HDG_S; vert_sq_s = 4'd2; horz_hdg_s = HDG_E; horz_sq_s = 4'd1; end // (+1,-2)
      8'h40: begin vert_hdg_s = HDG_S; vert_sq_s = 4'd1; horz_hdg_s = HDG_E; horz_sq_s = 4'd2; end // (+2,-1)
      8'h80: begin vert_hdg_s = HDG_N; vert_sq_s = 4'd1; horz_hdg_s = HDG_E; horz_sq_s = 4'd2; end // (+2,+1)
      default: begin
        vert_hdg_s = HDG_N;
        vert_sq_s  = 4'd0;
        horz_hdg_s = HDG_N;
        horz_sq_s  = 4'd0;
      end
    endcase
  end

  assign vert_cmd = pack_cmd(OP_MOVE,     vert_hdg_s, vert_sq_s);
  assign horz_cmd = pack_cmd(OP_MOVE_FAN, horz_hdg_s, horz_sq_s);

endmodule

// File: rtl/tour_cmd_seq.sv
// Command sequencer between the tour solver and the robot command processor.
// In IDLE, UART commands pass straight through. After start_tour it walks the
// stored moves by index and issues each move as a vertical then a horizontal
// command using the cmd_rdy / clr_cmd_rdy / send_resp handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_tour          one-cycle pulse: solver has a valid tour
//   move / mv_indx      move read from the solver at the current index
//   cmd_UART, cmd_rdy_UART, clr_cmd_rdy_UART  host command channel
//   cmd, cmd_rdy, clr_cmd_rdy, send_resp      command processor channel
//   resp                response byte toward the UART wrapper
// Only the state and index are registered; all outputs are decoded from them
// so the processor sees the leg command in the same cycle cmd_rdy rises.
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_t state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [15:0] vert_cmd_s;
  logic [15:0] horz_cmd_s;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd_s),
    .horz_cmd (horz_cmd_s)
  );

  // Next-state and move-index logic; each state reacts only to its own handshake
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    case (state_q)
      ST_IDLE: begin
        // start_tour wins over a pending UART command, which stays pending
        if (start_tour) begin
          state_d   = ST_VERT;
          mv_indx_d = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VERT: begin
        if (clr_cmd_rdy) begin
          state_d = ST_HOLD_V;
        end else begin
          state_d = ST_VERT;
        end
      end
      ST_HOLD_V: begin
        if (send_resp) begin
          state_d = ST_HORZ;
        end else begin
          state_d = ST_HOLD_V;
        end
      end
      ST_HORZ: begin
        if (clr_cmd_rdy) begin
          state_d = ST_HOLD_H;
        end else begin
          state_d = ST_HORZ;
        end
      end
      ST_HOLD_H: begin
        if (send_resp) begin
          if (mv_indx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end else begin
          state_d = ST_HOLD_H;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mv_indx_d = 5'd0;
      end
    endcase
  end

  // State and move-index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Output muxing: host pass-through in IDLE, tour legs otherwise
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    case (state_q)
      ST_IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_ACK;
      end
      ST_VERT: begin
        cmd     = vert_cmd_s;
        cmd_rdy = 1'b1;
      end
      ST_HOLD_V: begin
        cmd     = vert_cmd_s;
        cmd_rdy = 1'b0;
      end
      ST_HORZ: begin
        cmd     = horz_cmd_s;
        cmd_rdy = 1'b1;
      end
      ST_HOLD_H: begin
        cmd     = horz_cmd_s;
        cmd_rdy = 1'b0;
        // The last leg's response tells the host the whole tour is done
        if (mv_indx_q == LAST_IDX) begin
          resp = RESP_ACK;
        end else begin
          resp = RESP_POS;
        end
      end
      default: begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_ACK;
      end
    endcase
  end

  assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq. A behavioural model tracks the tour as
// "command number k of 48, offered or awaiting response" and derives every
// output from knight offsets with plain arithmetic; a negedge process compares
// the DUT against it each cycle. Directed steps pin literal values.
module tb_tour_cmd_seq;

  localparam int TOTAL_CMDS = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  logic [7:0] moves [32];
  assign move = moves[mv_indx];

  int checks = 0;
  int errors = 0;

  // model: tour active, command number (even = vertical, odd = horizontal), waiting for response
  bit m_active = 1'b0;
  int m_cnum = 0;
  bit m_wait = 1'b0;

  bit counting = 1'b0;
  int hs = 0;
  int prev_idx = 0;
  bit final_seen = 1'b0;

  tour_cmd_seq #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected leg command from knight offsets (dx east, dy north)
  function automatic logic [15:0] leg_cmd(input logic [7:0] m, input bit horiz);
    int dx, dy, mag;
    logic [7:0] hdg;
    dx = 0;
    dy = 0;
    if ($countones(m) == 1) begin
      for (int b = 0; b < 8; b++) begin
        if (m[b]) begin
          case (b)
            0: begin dx =  1; dy =  2; end
            1: begin dx = -1; dy =  2; end
            2: begin dx = -2; dy =  1; end
            3: begin dx = -2; dy = -1; end
            4: begin dx = -1; dy = -2; end
            5: begin dx =  1; dy = -2; end
            6: begin dx =  2; dy = -1; end
            default: begin dx = 2; dy = 1; end
          endcase
        end
      end
    end
    if (horiz) begin
      hdg = (dx > 0) ? 8'hBF : ((dx < 0) ? 8'h3F : 8'h00);
      mag = (dx < 0) ? -dx : dx;
      return {4'h3, hdg, 4'(mag)};
    end
    hdg = (dy < 0) ? 8'h7F : 8'h00;
    mag = (dy < 0) ? -dy : dy;
    return {4'h2, hdg, 4'(mag)};
  endfunction

  // Reference model update on each clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_cnum   <= 0;
      m_wait   <= 1'b0;
    end else if (!m_active) begin
      if (start_tour) begin
        m_active <= 1'b1;
        m_cnum   <= 0;
        m_wait   <= 1'b0;
      end
    end else if (!m_wait) begin
      if (clr_cmd_rdy) m_wait <= 1'b1;
    end else if (send_resp) begin
      m_wait <= 1'b0;
      if (m_cnum == TOTAL_CMDS - 1) m_active <= 1'b0;
      else m_cnum <= m_cnum + 1;
    end
  end

  // Per-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    chk("mv_indx", 16'(mv_indx), 16'(m_cnum / 2));
    if (!m_active) begin
      chk("idle_cmd", cmd, cmd_UART);
      chk("idle_cmd_rdy", 16'(cmd_rdy), 16'(cmd_rdy_UART));
      chk("idle_clr_uart", 16'(clr_cmd_rdy_UART), 16'(clr_cmd_rdy));
      chk("idle_resp", 16'(resp), 16'h00A5);
    end else if (!m_wait) begin
      chk("leg_cmd", cmd, leg_cmd(moves[m_cnum / 2], (m_cnum % 2) == 1));
      chk("leg_cmd_rdy", 16'(cmd_rdy), 16'h0001);
      chk("leg_clr_uart", 16'(clr_cmd_rdy_UART), 16'h0000);
      chk("leg_resp", 16'(resp), 16'h005A);
    end else begin
      chk("hold_cmd_rdy", 16'(cmd_rdy), 16'h0000);
      chk("hold_clr_uart", 16'(clr_cmd_rdy_UART), 16'h0000);
      chk("hold_resp", 16'(resp), (m_cnum == TOTAL_CMDS - 1) ? 16'h00A5 : 16'h005A);
    end
    if (counting) begin
      if (cmd_rdy && clr_cmd_rdy) hs++;
      if (int'(mv_indx) != prev_idx) begin
        chk("idx_step", 16'(mv_indx), 16'(prev_idx + 1));
        prev_idx = int'(mv_indx);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(5, 0) == 0) moves[i] = 8'($urandom);
      else moves[i] = 8'(1 << $urandom_range(7, 0));
    end
    moves[0] = 8'h01;
    moves[3] = 8'h08;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mv_indx", 16'(mv_indx), 16'h0000);
    chk("rst_resp", 16'(resp), 16'h00A5);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0000);
    rst_n = 1'b1;
    step();

    // host pass-through
    cmd_UART = 16'h2003;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("pass_cmd", cmd, 16'h2003);
    chk("pass_rdy", 16'(cmd_rdy), 16'h0001);
    chk("pass_resp", 16'(resp), 16'h00A5);
    step();
    clr_cmd_rdy = 1'b1;
    #1;
    chk("pass_clr_uart", 16'(clr_cmd_rdy_UART), 16'h0001);
    step();
    clr_cmd_rdy = 1'b0;
    #1;
    chk("pass_clr_uart_low", 16'(clr_cmd_rdy_UART), 16'h0000);

    // tour 1: start together with a UART command
    step();
    counting = 1'b1;
    hs = 0;
    prev_idx = 0;
    start_tour = 1'b1;
    #1;
    chk("start_idle_rdy", 16'(cmd_rdy), 16'h0001);
    step();
    start_tour = 1'b0;
    clr_cmd_rdy = 1'b1;
    #1;
    chk("v0_cmd", cmd, 16'h2002);
    chk("v0_rdy", 16'(cmd_rdy), 16'h0001);
    chk("v0_clr_uart", 16'(clr_cmd_rdy_UART), 16'h0000);
    step();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    cmd_rdy_UART = 1'b0;
    #1;
    chk("hv0_rdy", 16'(cmd_rdy), 16'h0000);
    step();
    send_resp = 1'b0;
    clr_cmd_rdy = 1'b1;
    #1;
    chk("h0_cmd", cmd, 16'h3BF1);
    chk("h0_resp", 16'(resp), 16'h005A);
    step();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;

    for (int n = 0; n < 3000 && m_active; n++) begin
      step();
      clr_cmd_rdy = 1'($urandom);
      send_resp = 1'($urandom);
      start_tour = (n == 40);
      #1;
      if (mv_indx == 5'd3 && cmd_rdy)
        chk("idx3_cmd", cmd, ((m_cnum % 2) == 1) ? 16'h33F2 : 16'h27F1);
      if (m_active && m_wait && m_cnum == TOTAL_CMDS - 1 && send_resp) begin
        chk("final_resp", 16'(resp), 16'h00A5);
        final_seen = 1'b1;
      end
    end
    start_tour = 1'b0;
    counting = 1'b0;
    chk("tour1_finished", 16'(m_active), 16'h0000);
    chk("final_resp_seen", 16'(final_seen), 16'h0001);
    chk("handshakes", 16'(hs), 16'd48);
    chk("last_idx", 16'(prev_idx), 16'd23);
    step();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("back_idle_cmd", cmd, 16'h1234);
    chk("back_idle_rdy", 16'(cmd_rdy), 16'h0001);

    // tour 2: reset in HOLD_H at index 10
    step();
    cmd_rdy_UART = 1'b0;
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (m_active && m_wait && m_cnum == 21) break;
      clr_cmd_rdy = 1'($urandom);
      send_resp = 1'($urandom);
    end
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    chk("reach_hold_h10", 16'(m_active && m_wait && m_cnum == 21), 16'h0001);
    chk("idx10", 16'(mv_indx), 16'd10);
    #1;
    rst_n = 1'b0;
    cmd_rdy_UART = 1'b1;
    cmd_UART = 16'hBEEF;
    #1;
    chk("rst_mid_idx", 16'(mv_indx), 16'h0000);
    chk("rst_mid_rdy", 16'(cmd_rdy), 16'h0001);
    chk("rst_mid_cmd", cmd, 16'hBEEF);
    chk("rst_mid_resp", 16'(resp), 16'h00A5);
    step();
    rst_n = 1'b1;
    step();

    // fully random traffic
    for (int n = 0; n < 2500; n++) begin
      step();
      cmd_UART = 16'($urandom);
      cmd_rdy_UART = 1'($urandom);
      clr_cmd_rdy = 1'($urandom);
      send_resp = 1'($urandom);
      start_tour = ($urandom_range(39, 0) == 0);
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
